flag_reg: RTL and testbench
===========================

# flag_reg

Condition-flag producer for the 16-bit pipelined core. It watches the instruction in EX, computes N, V and Z for flag-setting ALU ops, and holds them in an architectural flag register. It also exports a same-cycle forwarded copy of the flags. The branch-condition unit in the fetch/decode path consumes both outputs, using the same 3-bit {N,V,Z} encoding.

## Interface
- DATA_W, 16, ALU operand/result width; the sign bit is bit DATA_W-1.
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  pipeline stall; when high, the EX instruction does not retire flags this cycle.
- flush  input  1  squashes the EX instruction; no flag update.
- alu_valid  input  1  the EX stage holds a real (non-bubble) instruction.
- opcode  input  4  opcode of the EX instruction.
- alu_a  input  DATA_W  ALU operand A, signed.
- alu_b  input  DATA_W  ALU operand B, signed.
- alu_result  input  DATA_W  final ALU result, saturated for ADD/SUB.
- NVZflag  output  3  registered flags: [2]=N, [1]=V, [0]=Z.
- NVZ_fwd  output  3  combinational next-state flags, used for same-cycle forwarding to branch resolution.
- flag_wr  output  1  high when an update is committed at the coming edge.

## Operation
- Opcode classes:
  - ADD=4'h0 and SUB=4'h1 write N, V and Z.
  - XOR=4'h2, SLL=4'h4, SRA=4'h5 and ROR=4'h6 write Z only; N and V keep their old values.
  - RED=4'h3, PADDSB=4'h7 and all opcodes 4'h8..4'hF write nothing.
- Commit condition: flag_wr = alu_valid & ~stall & ~flush & (opcode is a flag-setting class).
- Z = (alu_result == 0).
- N = alu_result[DATA_W-1], i.e. the sign of the saturated result.
- V is computed internally from the operands, not from alu_result, using a raw DATA_W-bit wrap-around sum or difference r:
  - ADD: V = (a[msb]==b[msb]) & (r[msb]!=a[msb]), with r = a+b.
  - SUB: V = (a[msb]!=b[msb]) & (r[msb]!=a[msb]), with r = a-b.
- NVZ_fwd equals the would-be new register value when flag_wr=1. Fields the class does not write come from NVZflag. When flag_wr=0, NVZ_fwd = NVZflag.
- Priority at each edge:
  - rst clears the flags to 3'b000.
  - otherwise flush holds.
  - otherwise stall holds.
  - otherwise, if flag_wr, load NVZ_fwd.
  - otherwise hold.
- No other state is kept. Back-to-back flag writers update on consecutive edges, and each sees the previous result as its retained field values.

## Timing
- Reset: NVZflag=3'b000. flag_wr and NVZ_fwd follow their inputs combinationally; with alu_valid=0 during reset, both read as 0.
- Latency: the flags of an EX instruction appear on NVZflag one cycle after its EX cycle. They appear on NVZ_fwd in the same cycle, with zero latency.
- stall and flush are level-sensitive, per cycle. A stalled instruction that is still valid once stall drops commits then, exactly once.
- Reset mid-operation: rst wins over a concurrent flag_wr, and NVZflag becomes 000 on that edge.
- Stall and flush together: no update.
- V has no meaning for Z-only opcodes and is never written by them.

## Test plan
- Reset: assert rst for 2 cycles with alu_valid=1, ADD 0x0000+0x0000 → NVZflag=000 after every edge while rst is high. Deassert rst → the next edge gives 001.
- Positive overflow: ADD a=0x7FFF, b=0x0001, alu_result=0x7FFF → NVZ_fwd=010 in the same cycle, NVZflag=010 at the next edge. Then SUB a=0x8000, b=0x0001, alu_result=0x8000 → 110.
- Partial write: SUB 0x0000-0x0001, result 0xFFFF → 100. Then XOR with result 0x0000 → 101 (N retained). Then SLL with result 0x0010 → 100.
- Non-writers: from flags 101, issue RED, PADDSB and opcode 4'hA with alu_result=0 on consecutive cycles → flag_wr=0 and NVZflag stays 101 throughout.
- Stall/flush: ADD 0x0001+0x0001 with stall=1 for 3 cycles → flags unchanged and flag_wr=0. Then release stall → one update to 000. Separately, flush=1 on SUB 5-5 → Z stays unchanged. Also drive stall=1 and flush=1 together → no update.
- Bubble plus reset race: alu_valid=0 with an ADD opcode → no update. Then rst=1 coincident with a valid SUB 3-3 → NVZflag=000 (not 001).

Source files
------------

// File: rtl/flag_reg.sv
// Condition-flag register for the 16-bit pipelined core: derives {N,V,Z} from the
// EX-stage ALU op, holds them architecturally, and forwards the next value same-cycle.
module flag_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic [2:0]        NVZflag,
    output logic [2:0]        NVZ_fwd,
    output logic              flag_wr
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7
    } opcode_e;

    localparam int MSB = DATA_W - 1;

    logic              writes_nvz;
    logic              writes_z;
    logic [DATA_W-1:0] raw_sum;
    logic [DATA_W-1:0] raw_diff;
    logic              v_add;
    logic              v_sub;

    assign writes_nvz = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign writes_z   = (opcode == OP_XOR) || (opcode == OP_SLL) ||
                        (opcode == OP_SRA) || (opcode == OP_ROR);

    assign flag_wr = alu_valid & ~stall & ~flush & (writes_nvz | writes_z);

    // V comes from the unsaturated wrap-around result; alu_result is already clamped.
    assign raw_sum  = alu_a + alu_b;
    assign raw_diff = alu_a - alu_b;
    assign v_add    = (alu_a[MSB] == alu_b[MSB]) & (raw_sum[MSB]  != alu_a[MSB]);
    assign v_sub    = (alu_a[MSB] != alu_b[MSB]) & (raw_diff[MSB] != alu_a[MSB]);

    // NOTE: start from the held value so every path assigns NVZ_fwd and no latch is inferred.
    always_comb begin
        NVZ_fwd = NVZflag;
        if (flag_wr) begin
            NVZ_fwd[0] = (alu_result == '0);
            if (writes_nvz) begin
                NVZ_fwd[2] = alu_result[MSB];
                NVZ_fwd[1] = (opcode == OP_SUB) ? v_sub : v_add;
            end
        end
    end

    // NOTE: non-blocking assignment for state so all flops update together at the edge.
    // flag_wr already excludes flush and stall, so reset is the only override needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            NVZflag <= 3'b000;
        end else if (flag_wr) begin
            NVZflag <= NVZ_fwd;
        end
    end

endmodule

// File: tb/tb_flag_reg.sv
// Directed bench for flag_reg: hand-computed {N,V,Z} for each vector, checked on
// the forwarded path before the edge and on the register after it.
module tb_flag_reg;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        alu_valid;
    logic [3:0]  opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [2:0]  NVZflag;
    logic [2:0]  NVZ_fwd;
    logic        flag_wr;

    int checks = 0;
    int errors = 0;

    flag_reg #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .alu_valid  (alu_valid),
        .opcode     (opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .NVZflag    (NVZflag),
        .NVZ_fwd    (NVZ_fwd),
        .flag_wr    (flag_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] actual, input logic [2:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] r);
        alu_valid  = v;
        opcode     = op;
        alu_a      = a;
        alu_b      = b;
        alu_result = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a valid op, check forwarded value and write strobe, then the register.
    task automatic op_step(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] r,
                           input logic exp_wr, input logic [2:0] exp_nvz);
        drive(1'b1, op, a, b, r);
        check({tag, "_wr"}, {2'b00, flag_wr}, {2'b00, exp_wr});
        check({tag, "_fwd"}, NVZ_fwd, exp_nvz);
        tick();
        check({tag, "_reg"}, NVZflag, exp_nvz);
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 4'h0, 16'h0000, 16'h0000, 16'h0000);

        // Reset held two edges with a valid ADD present
        tick();
        check("rst_edge1", NVZflag, 3'b000);
        tick();
        check("rst_edge2", NVZflag, 3'b000);
        rst = 1'b0;
        #1;
        check("post_rst_fwd", NVZ_fwd, 3'b001);
        tick();
        check("post_rst_reg", NVZflag, 3'b001);

        // Overflow in both directions
        op_step("add_povf", 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 3'b010);
        op_step("sub_novf", 4'h1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 3'b110);
        op_step("add_nofl", 4'h0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 3'b110);

        // Partial writes: Z-only ops keep N and V
        op_step("sub_neg",  4'h1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 3'b100);
        op_step("xor_zero", 4'h2, 16'h1234, 16'h1234, 16'h0000, 1'b1, 3'b101);
        op_step("sll_nz",   4'h4, 16'h0001, 16'h0004, 16'h0010, 1'b1, 3'b100);
        op_step("sra_zero", 4'h5, 16'h0001, 16'h0004, 16'h0000, 1'b1, 3'b101);
        op_step("ror_nz",   4'h6, 16'h0005, 16'h0000, 16'h0005, 1'b1, 3'b100);
        op_step("xor_zero2",4'h2, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'b101);

        // Non-writers leave 101 untouched
        op_step("red",    4'h3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b101);
        op_step("paddsb", 4'h7, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b101);
        op_step("op_a",   4'hA, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b101);

        // Stall for three cycles, then one commit
        stall = 1'b1;
        for (int i = 0; i < 3; i++)
            op_step("stall", 4'h0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 3'b101);
        stall = 1'b0;
        op_step("stall_rel", 4'h0, 16'h0001, 16'h0001, 16'h0002, 1'b1, 3'b000);

        // Flush alone, then stall and flush together
        flush = 1'b1;
        op_step("flush", 4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'b000);
        stall = 1'b1;
        op_step("stall_flush", 4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'b000);
        stall = 1'b0;
        flush = 1'b0;

        // Bubble, then reset racing a valid writer
        op_step("set_neg", 4'h0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 3'b100);
        drive(1'b0, 4'h0, 16'h0005, 16'hFFFB, 16'h0000);
        check("bubble_wr", {2'b00, flag_wr}, 3'b000);
        check("bubble_fwd", NVZ_fwd, 3'b100);
        tick();
        check("bubble_reg", NVZflag, 3'b100);
        rst = 1'b1;
        drive(1'b1, 4'h1, 16'h0003, 16'h0003, 16'h0000);
        tick();
        check("rst_race", NVZflag, 3'b000);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
